// File: rtl/conv2_sched.sv
// Sequencer for the shared 2-D convolution MAC datapath. It walks every valid
// output pixel, issues one kernel tap per cycle, and strobes each finished pixel.
module conv2_sched #(
  parameter int SIZE    = 100,
  parameter int SIZEKer = 3,
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int KW = (SIZEKer > 1) ? $clog2(SIZEKer) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          stall,
  output logic          tap_valid,
  output logic [CW-1:0] img_row,
  output logic [CW-1:0] img_col,
  output logic [KW-1:0] ker_row,
  output logic [KW-1:0] ker_col,
  output logic          mac_clear,
  output logic          out_we,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          busy,
  output logic          done,
  output logic [1:0]    fsm_state
);

  // Handshake: start is sampled only in IDLE. While stall is high in ACCUM the
  // current tap is held and tap_valid stays low. abort beats everything else.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [KW-1:0] K_LAST = KW'(SIZEKer - 1);
  localparam logic [CW-1:0] O_LAST = CW'(SIZE - SIZEKer);

  state_t        state_q, state_d;
  logic [CW-1:0] row_q, row_d, col_q, col_d;
  logic [KW-1:0] kr_q, kr_d, kc_q, kc_d;
  logic          done_q, done_d;
  logic          busy_q, clear_q, we_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    done_d  = done_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
      kr_d    = '0;
      kc_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d = CLEAR;
            done_d  = 1'b0;
            row_d   = '0;
            col_d   = '0;
            kr_d    = '0;
            kc_d    = '0;
          end
        end
        CLEAR: begin
          state_d = ACCUM;
          kr_d    = '0;
          kc_d    = '0;
        end
        ACCUM: begin
          if (!stall) begin
            if (kc_q == K_LAST) begin
              kc_d = '0;
              // Last tap accepted: leave kr at 0 so the next CLEAR starts clean.
              if (kr_q == K_LAST) begin
                kr_d    = '0;
                state_d = WRITE;
              end else begin
                kr_d = kr_q + KW'(1);
              end
            end else begin
              kc_d = kc_q + KW'(1);
            end
          end
        end
        WRITE: begin
          state_d = CLEAR;
          if (col_q == O_LAST) begin
            col_d = '0;
            if (row_q == O_LAST) begin
              row_d   = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              row_d = row_q + CW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      clear_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
      clear_q <= (state_d == CLEAR);
      we_q    <= (state_d == WRITE);
    end
  end

  assign tap_valid = (state_q == ACCUM) && !stall;
  assign img_row   = row_q + CW'(kr_q);
  assign img_col   = col_q + CW'(kc_q);
  assign ker_row   = kr_q;
  assign ker_col   = kc_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign mac_clear = clear_q;
  assign out_we    = we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_conv2_sched.sv
// Bench for conv2_sched at SIZE=5, SIZEKer=3: a queue model of the expected tap
// and pixel order, checked every cycle, plus directed timing and control cases.
module tb_conv2_sched;
  localparam int SIZE    = 5;
  localparam int SIZEKER = 3;
  localparam int CW      = 3;
  localparam int KW      = 2;
  localparam int NOUT    = SIZE - SIZEKER + 1;

  logic          clock = 1'b0;
  logic          reset, start, abort, stall;
  logic          tap_valid, mac_clear, out_we, busy, done;
  logic [CW-1:0] img_row, img_col, out_row, out_col;
  logic [KW-1:0] ker_row, ker_col;
  logic [1:0]    fsm_state;

  conv2_sched #(.SIZE(SIZE), .SIZEKer(SIZEKER)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .stall(stall),
    .tap_valid(tap_valid), .img_row(img_row), .img_col(img_col),
    .ker_row(ker_row), .ker_col(ker_col), .mac_clear(mac_clear),
    .out_we(out_we), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] tap_q[$];
  logic [5:0] px_q[$];
  int taps_since_clear = 0;
  int we_count = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [9:0] tap_word(input int r, input int c, input int kr, input int kc);
    return {3'(r), 3'(c), 2'(kr), 2'(kc)};
  endfunction

  // Expected order: output pixels row-major, and within each pixel the kernel
  // taps row-major; image coordinate is pixel + kernel offset.
  task automatic load_model(input int passes);
    tap_q.delete();
    px_q.delete();
    for (int p = 0; p < passes; p++)
      for (int r = 0; r < NOUT; r++)
        for (int c = 0; c < NOUT; c++) begin
          px_q.push_back({3'(r), 3'(c)});
          for (int kr = 0; kr < SIZEKER; kr++)
            for (int kc = 0; kc < SIZEKER; kc++)
              tap_q.push_back(tap_word(r + kr, c + kc, kr, kc));
        end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (mac_clear) begin
        check("clear_without_tap", tap_valid, 0);
        taps_since_clear = 0;
      end
      if (tap_valid) begin
        check("tap_during_stall", stall, 0);
        check("tap_expected", tap_q.size() != 0, 1);
        if (tap_q.size() != 0)
          check("tap_coords", {img_row, img_col, ker_row, ker_col}, tap_q.pop_front());
        check("img_in_range", (img_row < SIZE) && (img_col < SIZE), 1);
        taps_since_clear++;
      end else if (busy && stall && !mac_clear && !out_we && tap_q.size() != 0) begin
        check("stall_frozen", {img_row, img_col, ker_row, ker_col}, tap_q[0]);
      end
      if (out_we) begin
        check("taps_per_pixel", taps_since_clear, SIZEKER * SIZEKER);
        check("pixel_expected", px_q.size() != 0, 1);
        if (px_q.size() != 0)
          check("pixel_coords", {out_row, out_col}, px_q.pop_front());
        we_count++;
      end
    end
  end

  // Cycle n=0 drives start; n=1 is the first cycle after start is sampled.
  task automatic run_pass(input bit hold, input int stall_from, input int stall_len,
                          input int abort_at, input int reset_at, input int passes,
                          output int clear_n, output int done_n1, output int done_n2);
    int n, rises;
    bit prev_done;
    clear_n = -1;
    done_n1 = -1;
    done_n2 = -1;
    rises = 0;
    prev_done = 1'b1;
    we_count = 0;
    @(posedge clock); #1;
    start = 1'b1;
    load_model(passes);
    n = 0;
    forever begin
      @(posedge clock); #1;
      n++;
      start = hold && (n < 120);
      stall = (n >= stall_from) && (n < stall_from + stall_len);
      abort = (n == abort_at);
      if (abort_at > 0 && n == abort_at + 1) begin
        tap_q.delete();
        px_q.delete();
      end
      if (reset_at > 0 && n == reset_at) begin
        check("pre_reset_out_we", out_we, 1);
        check("pre_reset_out_row", out_row, 2);
        #2 reset = 1'b1;
        #1;
        check("rst_async_out_we", out_we, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_done", done, 0);
        check("rst_async_mac_clear", mac_clear, 0);
        check("rst_async_tap_valid", tap_valid, 0);
        check("rst_async_out_coords", {out_row, out_col}, 0);
        check("rst_async_img_coords", {img_row, img_col, ker_row, ker_col}, 0);
        tap_q.delete();
        px_q.delete();
      end
      if (reset_at > 0 && n == reset_at + 1) reset = 1'b0;
      @(negedge clock);
      if (mac_clear && clear_n < 0) clear_n = n;
      if (n == 1) begin
        check("first_mac_clear", mac_clear, 1);
        check("first_busy", busy, 1);
        check("done_cleared", done, 0);
      end
      if (done && !prev_done) begin
        rises++;
        if (rises == 1) done_n1 = n;
        else done_n2 = n;
      end
      prev_done = done;
      if (abort_at > 0 && n == abort_at + 1) begin
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_strobes", {mac_clear, out_we}, 0);
        check("abort_out_coords", {out_row, out_col}, 0);
      end
      if (abort_at > 0 && n > abort_at + 1) check("abort_stays_idle", busy, 0);
      if (reset_at > 0 && n > reset_at + 1) check("reset_stays_idle", busy, 0);
      if (rises >= passes) break;
      if (abort_at > 0 && n >= abort_at + 20) break;
      if (reset_at > 0 && n >= reset_at + 15) break;
      if (n >= 400) begin
        check("pass_cycle_budget", 0, 1);
        break;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
  endtask

  int c_n, d1, d2;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_strobes", {tap_valid, mac_clear, out_we}, 0);
    check("reset_coords", {out_row, out_col, img_row, img_col, ker_row, ker_col}, 0);
    check("reset_state", fsm_state, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_no_start_busy", busy, 0);
    check("idle_no_start_mac_clear", mac_clear, 0);

    // Pin the model against hand-derived entries.
    load_model(1);
    check("model_tap_count", tap_q.size(), 81);
    check("model_px_1_2_first_tap", tap_q[45], 10'b001_010_00_00);
    check("model_px_1_2_fourth_tap", tap_q[48], 10'b010_010_01_00);
    check("model_px_1_2_last_tap", tap_q[53], 10'b011_100_10_10);
    check("model_px_order", px_q[3], 6'b001_000);
    tap_q.delete();
    px_q.delete();

    // Plain pass.
    run_pass(1'b0, 0, 0, 0, 0, 1, c_n, d1, d2);
    check("pass_start_to_clear", c_n, 1);
    check("pass_clear_to_done", d1 - c_n, 99);
    check("pass_pixel_count", we_count, 9);

    // done is sticky; abort beats start in IDLE.
    repeat (3) @(negedge clock);
    check("done_sticky", done, 1);
    @(posedge clock); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clock);
    check("abort_start_idle_busy", busy, 0);
    check("abort_start_idle_clear", mac_clear, 0);
    check("abort_start_done_kept", done, 1);

    // Four stalled ACCUM cycles in pixel (0,0).
    run_pass(1'b0, 5, 4, 0, 0, 1, c_n, d1, d2);
    check("stall_clear_to_done", d1 - c_n, 103);
    check("stall_pixel_count", we_count, 9);

    // Abort in the middle of pixel (1,1).
    run_pass(1'b0, 0, 0, 50, 0, 1, c_n, d1, d2);
    check("abort_pixel_count", we_count, 4);
    check("abort_no_done", d1, -1);

    // Restart after abort begins again at (0,0).
    run_pass(1'b0, 0, 0, 0, 0, 1, c_n, d1, d2);
    check("restart_clear_to_done", d1 - c_n, 99);
    check("restart_pixel_count", we_count, 9);

    // start held high: no mid-pass restart, then an immediate second pass.
    run_pass(1'b1, 0, 0, 0, 0, 2, c_n, d1, d2);
    check("held_first_done", d1, 100);
    check("held_second_done", d2, 200);
    check("held_pixel_count", we_count, 18);

    // Reset during WRITE of pixel (2,0).
    run_pass(1'b0, 0, 0, 0, 77, 1, c_n, d1, d2);
    check("reset_pass_pixel_count", we_count, 6);
    check("reset_pass_no_done", d1, -1);
    check("after_reset_done", done, 0);
    check("after_reset_state", fsm_state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
